uart_rx: RTL

//   16x-oversampling UART receiver. Sits directly downstream of uart_baudgen and

---
 rtl/uart_rx.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver with 2-of-3 mid-bit majority voting.
// Define UART_RX_PARITY_EN to add a parity bit and the o_parity_err port.
module uart_rx #(
   parameter int DATA_BITS   = 8,
   parameter int SYNC_STAGES = 2,
   parameter int PARITY_ODD  = 0
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_baud_x16,
   input  logic                 i_rx,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_valid,
   output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
   output logic                 o_parity_err,
`endif
   output logic                 o_busy
);

   if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_chk_bits
      $error("uart_rx: DATA_BITS must be 5..8");
   end
   if (SYNC_STAGES < 2) begin : g_chk_sync
      $error("uart_rx: SYNC_STAGES must be >= 2");
   end
   if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_chk_par
      $error("uart_rx: PARITY_ODD must be 0 or 1");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
   } state_e;

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d, tk;
   logic [3:0]             bit_q, bit_d;
   logic [1:0]             samp_q, samp_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   data_q, data_d;
   logic                   prev_q, prev_d;
   logic                   valid_q, valid_d;
   logic                   ferr_q, ferr_d;
   logic [SYNC_STAGES-1:0] sync_q, tag_q;
   logic                   rx_s, rx_ok, fall, maj, dec;
`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_d;
   logic                   perr_q, perr_d;
`endif

   // tag_q marks synchronizer contents as real line samples, so the
   // reset-preset ones never fake a 1->0 edge after reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '1;
         tag_q  <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
         tag_q  <= {tag_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign rx_s  = sync_q[SYNC_STAGES-1];
   assign rx_ok = rx_s & tag_q[SYNC_STAGES-1];
   assign fall  = prev_q & ~rx_s;
   assign tk    = cnt_q + 4'd1;
   assign dec   = (tk == 4'd9);
   assign maj   = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) |
                  (samp_q[1] & rx_s);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      samp_d  = samp_q;
      shift_d = shift_q;
      data_d  = data_q;
      prev_d  = prev_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_d   = par_q;
      perr_d  = 1'b0;
`endif
      if (i_baud_x16) begin
         prev_d = rx_ok;
         cnt_d  = tk;
         if (tk == 4'd7) samp_d[0] = rx_s;
         if (tk == 4'd8) samp_d[1] = rx_s;
         unique case (state_q)
            S_IDLE: begin
               cnt_d = 4'd0;
               bit_d = 4'd0;
               if (fall) state_d = S_START;
            end
            S_START: begin
               if (dec && maj) state_d = S_IDLE;
               else if (tk == 4'd0) state_d = S_DATA;
            end
            S_DATA: begin
               if (dec) begin
                  shift_d = {maj, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + 4'd1;
               end
               if (tk == 4'd0 && bit_q == 4'(DATA_BITS)) begin
`ifdef UART_RX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end
            end
            S_PARITY: begin
`ifdef UART_RX_PARITY_EN
               if (dec) par_d = (^shift_q) ^ maj ^ (PARITY_ODD != 0);
`endif
               if (tk == 4'd0) state_d = S_STOP;
            end
            S_STOP: begin
               if (dec) begin
                  data_d  = shift_q;
                  valid_d = maj;
                  ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
                  perr_d  = par_q;
`endif
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         samp_q  <= '0;
         shift_q <= '0;
         data_q  <= '0;
         prev_q  <= 1'b0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         samp_q  <= samp_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         prev_q  <= prev_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
         par_q   <= par_d;
         perr_q  <= perr_d;
`endif
      end
   end

   assign o_data      = data_q;
   assign o_valid     = valid_q;
   assign o_frame_err = ferr_q;
   assign o_busy      = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
   assign o_parity_err = perr_q;
`endif

endmodule
